// File: rtl/lfsr_encrypt_engine_pkg.sv
// Shared types, address map and LFSR helpers for the Program-1 encrypt engine and its decrypt twin.
package lfsr_encrypt_engine_pkg;

    localparam int AW = 8;

    localparam logic [AW-1:0] MSG_BASE  = 8'd0;
    localparam logic [AW-1:0] PRE_ADDR  = 8'd61;
    localparam logic [AW-1:0] TAP_ADDR  = 8'd62;
    localparam logic [AW-1:0] SEED_ADDR = 8'd63;
    localparam logic [AW-1:0] OUT_BASE  = 8'd64;
    localparam logic [AW-1:0] NCHAR     = 8'd64;
    localparam logic [7:0]    PRE_MIN   = 8'd10;
    localparam logic [7:0]    PRE_MAX   = 8'd26;
    localparam logic [7:0]    PAD_CHAR  = 8'h20;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARMED,
        S_LD_PRE,
        S_LD_TAP,
        S_LD_SEED,
        S_RD_CHAR,
        S_WR_CHAR,
        S_DONE
    } state_t;

    function automatic logic parity7(input logic [6:0] x);
        return ^x;
    endfunction

    // Galois-free Fibonacci step: shift left, feedback is the parity of the tapped bits.
    function automatic logic [6:0] lfsr7_next(input logic [6:0] state, input logic [6:0] taps);
        return {state[5:0], ^(state & taps)};
    endfunction

endpackage

// File: rtl/lfsr_encrypt_engine_lfsr7_step.sv
// One keystream step: encrypts a 7-bit char with the current LFSR state and produces the next state.
// Purely combinational; shared with the decrypt datapath.
module lfsr7_step
    import lfsr_encrypt_engine_pkg::*;
(
    input  logic [6:0] i_state,
    input  logic [6:0] i_taps,
    input  logic [6:0] i_plain,
    output logic [6:0] o_next,
    output logic [7:0] o_cipher
);

    logic [6:0] w_x;

    assign w_x      = i_plain ^ i_state;
    assign o_cipher = {parity7(w_x), w_x};
    assign o_next   = lfsr7_next(i_state, i_taps);

endmodule

// File: rtl/lfsr_encrypt_engine.sv
// Program-1 encrypt engine: loads config from data memory, writes 64 parity-tagged ciphertext bytes.
// Launch on registered req falling; ack 131 cycles after the first LD_PRE cycle, held until req rises.
module lfsr_encrypt_engine
    import lfsr_encrypt_engine_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_init,
    input  logic          i_req,
    output logic          o_ack,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_wr_en,
    output logic [7:0]    o_mem_wdata,
    input  logic [7:0]    i_mem_rdata
);

    state_t          r_state;
    state_t          w_next;
    logic            r_req;
    logic            r_ack;
    logic [7:0]      r_pre;
    logic [6:0]      r_taps;
    logic [6:0]      r_lfsr;
    logic [6:0]      r_plain;
    logic [AW-1:0]   r_idx;

    logic [AW-1:0]   w_off;
    logic            w_in_pad;
    logic [6:0]      w_rd_plain;
    logic [7:0]      w_pre_clamp;
    logic [6:0]      w_seed;
    logic [6:0]      w_lfsr_next;
    logic [7:0]      w_cipher;

    lfsr7_step u_step (
        .i_state  (r_lfsr),
        .i_taps   (r_taps),
        .i_plain  (r_plain),
        .o_next   (w_lfsr_next),
        .o_cipher (w_cipher)
    );

    assign w_off       = r_idx - r_pre;
    assign w_in_pad    = (r_idx < r_pre) || (w_off >= PRE_ADDR);
    assign w_rd_plain  = w_in_pad ? PAD_CHAR[6:0] : i_mem_rdata[6:0];
    assign w_pre_clamp = (i_mem_rdata < PRE_MIN) ? PRE_MIN :
                         (i_mem_rdata > PRE_MAX) ? PRE_MAX : i_mem_rdata;
    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    assign w_seed      = (i_mem_rdata[6:0] == 7'd0) ? 7'h01 : i_mem_rdata[6:0];

    always_comb begin
        w_next      = r_state;
        o_mem_addr  = '0;
        o_mem_wr_en = 1'b0;
        o_mem_wdata = 8'h00;
        case (r_state)
            S_IDLE:    if (r_req)  w_next = S_ARMED;
            S_ARMED:   if (!r_req) w_next = S_LD_PRE;
            S_LD_PRE: begin
                o_mem_addr = PRE_ADDR;
                w_next     = S_LD_TAP;
            end
            S_LD_TAP: begin
                o_mem_addr = TAP_ADDR;
                w_next     = S_LD_SEED;
            end
            S_LD_SEED: begin
                o_mem_addr = SEED_ADDR;
                w_next     = S_RD_CHAR;
            end
            S_RD_CHAR: begin
                o_mem_addr = (r_idx < r_pre) ? MSG_BASE : MSG_BASE + w_off;
                w_next     = S_WR_CHAR;
            end
            S_WR_CHAR: begin
                o_mem_addr  = OUT_BASE + r_idx;
                o_mem_wr_en = 1'b1;
                o_mem_wdata = w_cipher;
                w_next      = (r_idx == NCHAR - 8'd1) ? S_DONE : S_RD_CHAR;
            end
            S_DONE:    if (r_req)  w_next = S_ARMED;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_init) begin
        if (!i_init) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_ack   <= 1'b0;
            r_pre   <= '0;
            r_taps  <= '0;
            r_lfsr  <= '0;
            r_plain <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            r_req   <= i_req;
            r_ack   <= (w_next == S_DONE);
            case (r_state)
                S_LD_PRE:  r_pre  <= w_pre_clamp;
                S_LD_TAP:  r_taps <= i_mem_rdata[6:0];
                S_LD_SEED: begin
                    r_lfsr <= w_seed;
                    r_idx  <= '0;
                end
                S_RD_CHAR: r_plain <= w_rd_plain;
                S_WR_CHAR: begin
                    r_lfsr <= w_lfsr_next;
                    r_idx  <= r_idx + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_ack = r_ack;

endmodule

// File: tb/tb_lfsr_encrypt_engine.sv
// Directed-plus-random bench for lfsr_encrypt_engine with a behavioural memory and cipher model.
module tb_lfsr_encrypt_engine;

    logic       i_clk;
    logic       i_init;
    logic       i_req;
    logic       o_ack;
    logic [7:0] o_mem_addr;
    logic       o_mem_wr_en;
    logic [7:0] o_mem_wdata;
    logic [7:0] i_mem_rdata;

    logic [7:0] mem [256];
    logic [7:0] out_img [64];
    logic [7:0] exp_img [64];
    logic [6:0] exp_plain [64];
    logic       clr;
    int         wr_count;
    int         checks;
    int         errors;

    lfsr_encrypt_engine dut (
        .i_clk       (i_clk),
        .i_init      (i_init),
        .i_req       (i_req),
        .o_ack       (o_ack),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wr_en (o_mem_wr_en),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    assign i_mem_rdata = mem[o_mem_addr];

    initial wr_count = 0;
    always @(posedge i_clk) begin
        if (clr) begin
            for (int k = 0; k < 64; k++) out_img[k] <= 8'h00;
        end else if (o_mem_wr_en) begin
            if (o_mem_addr >= 8'd64 && o_mem_addr < 8'd128)
                out_img[o_mem_addr - 8'd64] <= o_mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic setup(input logic [7:0] taps, input logic [7:0] seed, input logic [7:0] pre);
        mem[61] = pre;
        mem[62] = taps;
        mem[63] = seed;
    endtask

    task automatic fill_spaces();
        for (int k = 0; k < 61; k++) mem[k] = 8'h20;
    endtask

    // Reference: clamp pre, pad, XOR with the keystream, put the 7-bit parity on top.
    task automatic compute_model(input logic [7:0] taps, input logic [7:0] seed, input logic [7:0] preb);
        int pre, s, plain, x, fb;
        pre = (preb < 10) ? 10 : (preb > 26) ? 26 : int'(preb);
        s   = int'(seed) & 127;
        if (s == 0) s = 1;
        for (int i = 0; i < 64; i++) begin
            if (i < pre || (i - pre) >= 61) plain = 32;
            else                             plain = int'(mem[i - pre]);
            x            = (plain ^ s) & 127;
            exp_plain[i] = 7'(plain & 127);
            exp_img[i]   = 8'(x | (($countones(x) & 1) << 7));
            fb           = $countones(s & int'(taps) & 127) & 1;
            s            = ((s << 1) | fb) & 127;
        end
    endtask

    task automatic check_image(input string tag);
        int mism = 0;
        for (int i = 0; i < 64; i++) if (out_img[i] !== exp_img[i]) mism++;
        check(tag, 32'(mism), 32'd0);
    endtask

    // Independent decrypt: parity must be even overall, and XOR with keystream recovers the padded text.
    task automatic decrypt_score(input string tag, input logic [7:0] taps, input logic [7:0] seed);
        int s, y, fb, score;
        s = int'(seed) & 127;
        if (s == 0) s = 1;
        score = 0;
        for (int i = 0; i < 64; i++) begin
            y = int'(out_img[i]);
            if (($countones(y) % 2 == 0) && (((y & 127) ^ s) == int'(exp_plain[i]))) score++;
            fb = $countones(s & int'(taps) & 127) & 1;
            s  = ((s << 1) | fb) & 127;
        end
        check(tag, 32'(score), 32'd64);
    endtask

    task automatic clear_out();
        @(negedge i_clk);
        clr = 1'b1;
        @(negedge i_clk);
        clr = 1'b0;
    endtask

    // Cycle counts are taken in negedges after req falls; LD_PRE occupies count 2.
    task automatic run(output int t_ack, output int t_wr);
        i_req = 1'b1;
        repeat (3) @(negedge i_clk);
        i_req = 1'b0;
        t_ack = -1;
        t_wr  = -1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge i_clk);
            if (t_wr < 0 && o_mem_wr_en) t_wr = c;
            if (o_ack) begin
                t_ack = c;
                break;
            end
        end
    endtask

    initial begin
        string      msg;
        logic [7:0] tap_list [9];
        logic [7:0] seed, pre;
        int         t_ack, t_wr, snap;
        logic       held;

        checks = 0;
        errors = 0;
        clr    = 1'b0;
        i_req  = 1'b0;
        i_init = 1'b0;
        for (int k = 0; k < 256; k++) mem[k] = 8'h00;
        fill_spaces();
        msg = "Knowledge comes, but wisdom lingers";
        tap_list = '{8'h60, 8'h48, 8'h78, 8'h72, 8'h6A, 8'h69, 8'h5C, 8'h7E, 8'h7B};

        repeat (2) @(negedge i_clk);
        check("rst_ack", 32'(o_ack), 32'd0);
        check("rst_wr_en", 32'(o_mem_wr_en), 32'd0);
        check("rst_addr", 32'(o_mem_addr), 32'd0);
        check("rst_wdata", 32'(o_mem_wdata), 32'd0);
        i_init = 1'b1;
        clear_out();

        // Test 1: known vector
        setup(8'h60, 8'h01, 8'd10);
        run(t_ack, t_wr);
        check("t1_ack_lat", 32'(t_ack), 32'd133);
        check("t1_first_wr", 32'(t_wr), 32'd6);
        check("t1_b0", 32'(out_img[0]), 32'h21);
        check("t1_b1", 32'(out_img[1]), 32'h22);
        check("t1_b2", 32'(out_img[2]), 32'h24);
        check("t1_b3", 32'(out_img[3]), 32'h28);
        check("t1_b4", 32'(out_img[4]), 32'h30);
        check("t1_b5", 32'(out_img[5]), 32'h00);
        check("t1_b6", 32'(out_img[6]), 32'hE1);
        compute_model(8'h60, 8'h01, 8'd10);
        check_image("t1_image");

        // Test 2: zero seed promoted to 1
        clear_out();
        setup(8'h60, 8'h00, 8'd10);
        run(t_ack, t_wr);
        check_image("t2_zero_seed");

        // Test 3: pre clamps at both ends
        clear_out();
        setup(8'h60, 8'h01, 8'd5);
        run(t_ack, t_wr);
        check_image("t3_pre_low");
        clear_out();
        setup(8'h60, 8'h01, 8'd31);
        run(t_ack, t_wr);
        compute_model(8'h60, 8'h01, 8'd26);
        check_image("t3_pre_high");

        // Test 4: real message, every tap pattern, random seed and pre
        for (int k = 0; k < msg.len(); k++) mem[k] = msg[k];
        for (int t = 0; t < 9; t++) begin
            seed = 8'($urandom_range(1, 127));
            pre  = 8'($urandom_range(5, 31));
            clear_out();
            setup(tap_list[t], seed, pre);
            run(t_ack, t_wr);
            compute_model(tap_list[t], seed, pre);
            check_image($sformatf("t4_image_tap%0h", tap_list[t]));
            decrypt_score($sformatf("t4_score_tap%0h", tap_list[t]), tap_list[t], seed);
        end

        // Test 5: async init mid-run
        fill_spaces();
        clear_out();
        setup(8'h60, 8'h01, 8'd10);
        i_req = 1'b1;
        repeat (3) @(negedge i_clk);
        i_req = 1'b0;
        repeat (42) @(negedge i_clk);
        #2 i_init = 1'b0;
        #1;
        check("t5_ack_async", 32'(o_ack), 32'd0);
        check("t5_wr_en_async", 32'(o_mem_wr_en), 32'd0);
        snap = wr_count;
        @(negedge i_clk);
        i_init = 1'b1;
        repeat (20) @(negedge i_clk);
        check("t5_no_writes", 32'(wr_count - snap), 32'd0);
        clear_out();
        run(t_ack, t_wr);
        compute_model(8'h60, 8'h01, 8'd10);
        check("t5_rerun_lat", 32'(t_ack), 32'd133);
        check_image("t5_rerun_image");

        // Test 6: DONE holds while req stays low, then relaunch
        snap = wr_count;
        held = 1'b1;
        repeat (50) begin
            @(negedge i_clk);
            if (!o_ack) held = 1'b0;
        end
        check("t6_ack_held", 32'(held), 32'd1);
        check("t6_no_writes", 32'(wr_count - snap), 32'd0);
        clear_out();
        run(t_ack, t_wr);
        check("t6_second_lat", 32'(t_ack), 32'd133);
        check_image("t6_second_image");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
